// File: rtl/bram_port_arbiter_if.sv
// Bundle of requester handshakes and BRAM pins shared by the two-port BRAM arbiter.
// The master side is the requesters plus the BRAM; the slave side is the arbiter.
interface bram_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                  req0, req1;
    logic                  we0, we1;
    logic [ADDR_WIDTH-1:0] addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  lock0, lock1;
    logic                  gnt0, gnt1;
    logic                  rvalid0, rvalid1;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;
    logic                  err0, err1;
    logic                  en;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] to_BRAM;
    logic [DATA_WIDTH-1:0] from_BRAM;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        input  en, write_enable, addr, to_BRAM,
        output from_BRAM
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock0, lock1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        output en, write_enable, addr, to_BRAM,
        input  from_BRAM
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port BRAM, with burst lock and read return routing.
// Define BRAM_ARB_FIXED_PRIO_EN to make port 0 win every unlocked contention.
module bram_port_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int SIZE       = 4096
) (
    input logic clk,
    input logic rst,
    bram_port_arbiter_if.slave bus
);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_P0   = 2'd1;
    localparam logic [1:0] OWN_P1   = 2'd2;
    localparam logic [ADDR_WIDTH:0] SIZE_LIM = SIZE[ADDR_WIDTH:0];

    logic [1:0]            owner;
`ifndef BRAM_ARB_FIXED_PRIO_EN
    logic                  last_grant;
`endif
    logic                  gnt0_c, gnt1_c;
    logic                  granted, sel;
    logic                  sel_we, sel_lock, in_range;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  s1_valid, s1_port, s1_rd, s1_err;
    logic                  s2_valid, s2_port, s2_rd, s2_err;
    logic                  rv0, rv1;

    // A locked owner that still requests beats everyone; otherwise the port not granted last wins.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!rst) begin
            if (owner == OWN_P0 && bus.req0) begin
                gnt0_c = 1'b1;
            end else if (owner == OWN_P1 && bus.req1) begin
                gnt1_c = 1'b1;
            end else if (bus.req0 && bus.req1) begin
`ifdef BRAM_ARB_FIXED_PRIO_EN
                gnt0_c = 1'b1;
`else
                if (last_grant) gnt0_c = 1'b1;
                else            gnt1_c = 1'b1;
`endif
            end else begin
                gnt0_c = bus.req0;
                gnt1_c = bus.req1;
            end
        end
    end

    assign bus.gnt0  = gnt0_c;
    assign bus.gnt1  = gnt1_c;
    assign granted   = gnt0_c | gnt1_c;
    assign sel       = gnt1_c;
    assign sel_we    = sel ? bus.we1    : bus.we0;
    assign sel_lock  = sel ? bus.lock1  : bus.lock0;
    assign sel_addr  = sel ? bus.addr1  : bus.addr0;
    assign sel_wdata = sel ? bus.wdata1 : bus.wdata0;
    assign in_range  = {1'b0, sel_addr} < SIZE_LIM;

    // Out-of-range beats are still accepted but never reach the BRAM pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.en           <= 1'b0;
            bus.write_enable <= 1'b0;
            bus.addr         <= '0;
            bus.to_BRAM      <= '0;
            owner            <= OWN_NONE;
`ifndef BRAM_ARB_FIXED_PRIO_EN
            last_grant       <= 1'b1;
`endif
        end else if (granted) begin
            bus.en           <= in_range;
            bus.write_enable <= sel_we & in_range;
            bus.addr         <= sel_addr;
            bus.to_BRAM      <= sel_wdata;
            owner            <= sel_lock ? (sel ? OWN_P1 : OWN_P0) : OWN_NONE;
`ifndef BRAM_ARB_FIXED_PRIO_EN
            last_grant       <= sel;
`endif
        end else begin
            bus.en           <= 1'b0;
            bus.write_enable <= 1'b0;
            owner            <= OWN_NONE;
        end
    end

    // Two-stage tag pipeline lines each read or error up with the BRAM's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_port  <= 1'b0;
            s1_rd    <= 1'b0;
            s1_err   <= 1'b0;
            s2_valid <= 1'b0;
            s2_port  <= 1'b0;
            s2_rd    <= 1'b0;
            s2_err   <= 1'b0;
        end else begin
            s1_valid <= granted & (~sel_we | ~in_range);
            s1_port  <= sel;
            s1_rd    <= ~sel_we;
            s1_err   <= ~in_range;
            s2_valid <= s1_valid;
            s2_port  <= s1_port;
            s2_rd    <= s1_rd;
            s2_err   <= s1_err;
        end
    end

    always_comb begin
        rv0         = s2_valid & s2_rd & ~s2_port;
        rv1         = s2_valid & s2_rd &  s2_port;
        bus.rvalid0 = rv0;
        bus.rvalid1 = rv1;
        bus.err0    = s2_valid & s2_err & ~s2_port;
        bus.err1    = s2_valid & s2_err &  s2_port;
        bus.rdata0  = (rv0 && !s2_err) ? bus.from_BRAM : '0;
        bus.rdata1  = (rv1 && !s2_err) ? bus.from_BRAM : '0;
    end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares the single-port BRAM between two requesters: port 0 is the UART command/traffic controller, port 1 is a secondary client such as a DMA or streaming engine.
- Serialises accesses at one per cycle using round-robin arbitration, with an optional burst lock.
- Drives the BRAM enable, write, address and data pins, and routes read data back to the requester that issued the read.
- Sits between the requesters and the BRAM instance.

Parameters:
- DATA_WIDTH, 8, data width of the BRAM and both ports.
- ADDR_WIDTH, 12, address width.
- SIZE, 4096, number of valid BRAM words. Addresses at or above SIZE are out of range.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- req0/req1  input  1  access request. Held with its qualifiers until gnt.
- we0/we1  input  1  1 = write, 0 = read.
- addr0/addr1  input  ADDR_WIDTH  access address.
- wdata0/wdata1  input  DATA_WIDTH  write data.
- lock0/lock1  input  1  keep ownership for back-to-back beats.
- gnt0/gnt1  output  1  combinational; request accepted this cycle.
- rvalid0/rvalid1  output  1  read data valid (1-cycle pulse).
- rdata0/rdata1  output  DATA_WIDTH  read data, meaningful only while rvalid.
- err0/err1  output  1  out-of-range access; pulses with the rvalid timing.
- en  output  1  BRAM enable (registered).
- write_enable  output  1  BRAM write enable (registered).
- addr  output  ADDR_WIDTH  BRAM address (registered).
- to_BRAM  output  DATA_WIDTH  BRAM write data (registered).
- from_BRAM  input  DATA_WIDTH  BRAM read data, valid 1 cycle after en.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high, on rst, sampled at posedge clk.
- Reset values:
  - en, write_enable, addr, to_BRAM, all rvalid and all err = 0.
  - last_grant = 1, so port 0 wins the first contention.
  - owner = none.
- Arbitration:
  - Combinational, evaluated each cycle.
  - If owner is valid and its req=1, the owner is granted regardless of the other port.
  - Otherwise, if exactly one req=1, that port is granted.
  - If both req=1, the port other than last_grant is granted.
  - At most one gnt is high per cycle.
  - gnt is never asserted while rst=1.
- Issue, at the posedge ending a grant cycle t:
  - en <= (addr_x < SIZE).
  - write_enable <= we_x & (addr_x < SIZE).
  - addr <= addr_x; to_BRAM <= wdata_x.
  - last_grant <= x.
  - owner <= lock_x ? x : none.
  - With no grant, en and write_enable <= 0, and addr/to_BRAM hold their values.
- Requester handshake:
  - On seeing gnt the requester may drop req or present the next access in the following cycle.
  - One access per cycle throughput, with no bubbles between grants.
- Lock:
  - Ownership persists while the owner keeps lock=1 and req=1.
  - If the owner drops req, ownership is released that cycle and the other port may be granted.
  - Dropping lock on a granted beat releases ownership after that beat.
- Read latency:
  - A read granted in cycle t gives rvalid_x=1 in cycle t+2.
  - rdata_x = from_BRAM in that cycle.
  - Implemented as a 2-stage per-port tag pipeline {valid, port, err}.
  - Writes produce no rvalid.
- Out of range (addr_x >= SIZE):
  - The request is still granted; no BRAM access is made.
  - err_x pulses in cycle t+2 for both reads and writes.
  - For a read, rvalid_x also pulses with rdata_x = 0.
- Back-to-back reads from alternating ports return in grant order, one per cycle, each routed only to its issuer.
- rdata of the non-valid port is driven 0.
- Reset mid-operation:
  - The pipeline is flushed and in-flight reads are dropped, with no rvalid after reset.
  - Ownership and pointer return to their reset values.
- Same-address write then read, from any ports in consecutive grants: the read returns the new data, because the BRAM is serial.

Optional Feature:
- BRAM_ARB_FIXED_PRIO_EN defined:
  - On contention without a lock, port 0 always wins.
  - last_grant is unused.
  - Lock behaviour is unchanged.
- Undefined: round-robin as above.

Test Plan:
- Single read: write 0xA5 to addr 0x010 via port 0, then read 0x010 via port 0 -> gnt0 same cycle as req; en=1, write_enable=0 next cycle; rvalid0=1 with rdata0=0xA5 two cycles after gnt; rvalid1 stays 0.
- Contention: after reset, req0 and req1 held high continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; each port sees 3 gnt pulses.
- Lock:
  - Stimulus: port 1 issues a 4-beat read burst at 0x100-0x103 with lock1=1, while req0 is held high.
  - Required: gnt1 for 4 consecutive cycles; gnt0 only on the 5th cycle; rvalid1 data matches preloaded memory in order.
- Out of range: port 1 reads addr 0xFFF with SIZE=4000 -> gnt1=1; en stays 0; err1=1 and rvalid1=1 with rdata1=0x00 at t+2.
- Reset mid-read: rst asserted the cycle after a port 0 read grant -> no rvalid0 or err0 afterward; en=0; first contention after reset goes to port 0.
- Fixed priority, with BRAM_ARB_FIXED_PRIO_EN defined: both req held 4 cycles -> gnt0 all 4 cycles; gnt1 never asserted.
